// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the data-memory load/store front end.
// Holds access-size codes, the controller state enum, big-endian lane offset
// constants and small decode helpers used by mem_access_ctrl and mem_lane_align.
package mem_access_pkg;

  // Access size encodings; 2'b11 is an alias for a word access.
  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  // Big-endian byte offsets within a word: offset 0 is bits 31:24.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

  // Halfword select is byte-address bit 1: 0 -> bits 31:16, 1 -> bits 15:0.
  localparam logic OFF_H0 = 1'b0;
  localparam logic OFF_H1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_SETUP,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == SZ_WORD_ALT);
  endfunction

  // True when the byte offset does not match the natural alignment of the size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || (is_word(size) && (off != OFF_B0));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational big-endian lane logic.
// Extract: pick byte/half/word lane from a RAM word and sign/zero extend.
// Merge: overlay right-justified store data onto the old word at the lane
// selected by offset and size. Halves use offset bit 1 only, words ignore the
// offset, so a misaligned access in the unchecked build lands on the
// containing aligned lane.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_extract,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and extension for loads.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      OFF_B0: w_byte = i_word[31:24];
      OFF_B1: w_byte = i_word[23:16];
      OFF_B2: w_byte = i_word[15:8];
      OFF_B3: w_byte = i_word[7:0];
      default: w_byte = i_word[7:0];
    endcase
    w_half = (i_off[1] == OFF_H0) ? i_word[31:16] : i_word[15:0];
    if (is_word(i_size)) begin
      o_extract = i_word;
    end else if (i_size == SZ_HALF) begin
      o_extract = {{16{i_signed & w_half[15]}}, w_half};
    end else begin
      o_extract = {{24{i_signed & w_byte[7]}}, w_byte};
    end
  end

  // Per-byte-lane merge: each lane either keeps the old byte or takes a new one.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       w_sel;
      logic [7:0] w_new;

      // Decide whether this lane is written and which store byte feeds it.
      always_comb begin
        w_sel = 1'b0;
        w_new = i_new[31-8*gi -: 8];
        if (is_word(i_size)) begin
          w_sel = 1'b1;
          w_new = i_new[31-8*gi -: 8];
        end else if (i_size == SZ_HALF) begin
          w_sel = (LANE[1] == i_off[1]);
          w_new = LANE[0] ? i_new[7:0] : i_new[15:8];
        end else begin
          w_sel = (LANE == i_off);
          w_new = i_new[7:0];
        end
      end

      assign o_merged[31-8*gi -: 8] = w_sel ? w_new : i_old[31-8*gi -: 8];
    end
  endgenerate

  // Tie-off reference keeps the half-select constants tied to their meaning.
  logic w_h1_unused;
  assign w_h1_unused = OFF_H1;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store front end for the MIPS data memory.
// One request in flight; loads read then respond, word stores set up and
// write, sub-word stores read-modify-write. All RAM-facing outputs are
// registered; ram_rw drops to 0 for exactly the WRITE cycle.
// Optional feature macro: MEM_ACCESS_ALIGN_CHECK_EN (misaligned half/word
// requests answer with resp_err=1 after one cycle and never touch the RAM).
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW+1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_t        r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic [1:0]    r_off;
  logic          r_signed;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_old_word;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_rw;
  logic [DW-1:0] r_ram_wdata;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_rdata;
  logic [DW-1:0] w_extract;
  logic [DW-1:0] w_merged;

  // Extract works on the live RAM word during READ; merge uses the captured old word.
  mem_lane_align u_lane (
    .i_word    (ram_rdata),
    .i_old     (r_old_word),
    .i_new     (r_wdata),
    .i_off     (r_off),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .o_extract (w_extract),
    .o_merged  (w_merged)
  );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic r_resp_err;
`endif

  // Controller FSM with all RAM and response outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_off        <= OFF_B0;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_old_word   <= '0;
      r_ram_addr   <= '0;
      r_ram_rw     <= 1'b1;
      r_ram_wdata  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_resp_valid <= 1'b0;
          r_ram_rw     <= 1'b1;
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_off      <= req_addr[1:0];
            r_signed   <= req_signed;
            r_wdata    <= req_wdata;
            r_ram_addr <= req_addr[AW+1:2];
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            if (is_misaligned(req_size, req_addr[1:0])) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
`else
            begin
`endif
              // Only a full-word store can skip reading the old word.
              if (req_we && is_word(req_size)) begin
                r_state <= ST_SETUP;
              end else begin
                r_state <= ST_READ;
              end
            end
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_old_word <= ram_rdata;
            r_state    <= ST_SETUP;
          end else begin
            r_resp_rdata <= w_extract;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            r_resp_err   <= 1'b0;
`endif
            r_resp_valid <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_SETUP: begin
          r_ram_wdata <= w_merged;
          r_ram_rw    <= 1'b0;
          r_state     <= ST_WRITE;
        end
        ST_WRITE: begin
          r_ram_rw     <= 1'b1;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
          r_resp_err   <= 1'b0;
`endif
          r_state      <= ST_DONE;
        end
        ST_DONE: begin
          r_resp_valid <= 1'b0;
          r_ram_rw     <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_ram_rw <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign ram_addr   = r_ram_addr;
  assign ram_rw     = r_ram_rw;
  assign ram_wdata  = r_ram_wdata;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural
// word RAM. Expected responses and RAM writes come from a reference memory
// kept by the bench; MEM_ACCESS_ALIGN_CHECK_EN selects the error expectations.
module tb_mem_access_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_signed = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_rw;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  mem_access_ctrl #(.AW(AW), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_rw     (ram_rw),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, write on the rising edge while rw=0.
  logic [31:0] ram_mem [0:15];
  logic        mem_clear = 1'b1;
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 32'h0;
    end else if (!ram_rw) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
    int          nwr;
    logic [3:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_rdata = 32'h0;
  logic        last_err   = 1'b0;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
    int          sh;
    logic [31:0] v;
    if (sz[1]) return w;
    if (sz == 2'b01) begin
      sh = off[1] ? 0 : 16;
      v  = (w >> sh) & 32'h0000FFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
      return v;
    end
    sh = (3 - int'(off)) * 8;
    v  = (w >> sh) & 32'h000000FF;
    if (sg && v[7]) v = v | 32'hFFFFFF00;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [1:0] off);
    int          sh;
    logic [31:0] m;
    if (sz[1]) return wd;
    if (sz == 2'b01) begin
      sh = off[1] ? 0 : 16;
      m  = 32'h0000FFFF << sh;
    end else begin
      sh = (3 - int'(off)) * 8;
      m  = 32'h000000FF << sh;
    end
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  // Drive one request and leave req_valid high; push its expectation on acceptance.
  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [5:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic        err;
    int          lat;
    logic [3:0]  idx;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
    chk("ready_wait", {31'h0, req_ready}, 32'h1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    chk("hold_rdata", resp_rdata, last_rdata);
    chk("hold_err", {31'h0, resp_err}, {31'h0, last_err});
    idx = addr[5:2];
    err = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    err = ((sz == 2'b01) && addr[0]) || (sz[1] && (addr[1:0] != 2'b00));
`endif
    e.rdata = 32'h0;
    e.err   = err;
    e.nwr   = 0;
    e.waddr = idx;
    e.wdata = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat     = 2;
      e.rdata = ref_load(ref_mem[idx], sz, sg, addr[1:0]);
    end else begin
      lat          = sz[1] ? 3 : 4;
      e.wdata      = ref_store(ref_mem[idx], wd, sz, addr[1:0]);
      e.nwr        = 1;
      ref_mem[idx] = e.wdata;
    end
    e.exp_cyc = cyc + lat;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Response monitor: pops the scoreboard and checks data, timing and RAM writes.
  int          wr_cnt = 0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  int          wr_cyc = 0;
  int          n_txn = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (!ram_rw) begin
        wr_cnt++;
        wr_addr = ram_addr;
        wr_data = ram_wdata;
        wr_cyc  = cyc;
      end
      if (resp_valid) begin
        chk("resp_expected", {31'h0, (sb_q.size() != 0)}, 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", {31'h0, resp_err}, {31'h0, e.err});
          chk("latency", cyc, e.exp_cyc);
          chk("write_count", wr_cnt, e.nwr);
          if (e.nwr != 0) begin
            chk("write_addr", {28'h0, wr_addr}, {28'h0, e.waddr});
            chk("write_data", wr_data, e.wdata);
            chk("write_cycle", wr_cyc, e.exp_cyc - 1);
          end
          last_rdata = e.rdata;
          last_err   = e.err;
          n_txn++;
          $display("txn %0d: rdata=%08h err=%0b writes=%0d cyc=%0d", n_txn, resp_rdata, resp_err, wr_cnt, cyc);
        end
        wr_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rsz;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Asynchronous reset before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_ram_rw", {31'h0, ram_rw}, 32'h1);
    chk("rst_ram_addr", {28'h0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    repeat (3) @(negedge clk);
    rst       = 1'b0;
    mem_clear = 1'b0;

    // Word store and load-back.
    send(1'b1, 2'b10, 1'b0, 6'h08, 32'hDEADBEEF);
    send(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);

    // Sub-word read-modify-write.
    send(1'b1, 2'b10, 1'b0, 6'h08, 32'h11223344);
    send(1'b1, 2'b00, 1'b0, 6'h09, 32'h000000AA);
    send(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    send(1'b1, 2'b01, 1'b0, 6'h0A, 32'h0000BEEF);
    send(1'b0, 2'b11, 1'b0, 6'h08, 32'h0);

    // Lane extraction with sign and zero extension.
    send(1'b1, 2'b10, 1'b0, 6'h08, 32'h112233F0);
    send(1'b0, 2'b00, 1'b1, 6'h0B, 32'h0);
    send(1'b0, 2'b00, 1'b0, 6'h0B, 32'h0);
    send(1'b0, 2'b01, 1'b1, 6'h0A, 32'h0);
    send(1'b0, 2'b01, 1'b1, 6'h08, 32'h0);
    send(1'b0, 2'b00, 1'b1, 6'h08, 32'h0);
    send(1'b1, 2'b10, 1'b0, 6'h0C, 32'h8001C0DE);
    send(1'b0, 2'b01, 1'b1, 6'h0C, 32'h0);
    send(1'b0, 2'b01, 1'b0, 6'h0C, 32'h0);

    // Misaligned accesses: error with the check enabled, aligned lane otherwise.
    send(1'b1, 2'b10, 1'b0, 6'h04, 32'hCAFEF00D);
    send(1'b0, 2'b10, 1'b0, 6'h06, 32'h0);
    send(1'b1, 2'b01, 1'b0, 6'h05, 32'h00001234);
    send(1'b1, 2'b10, 1'b0, 6'h07, 32'h55667788);
    send(1'b0, 2'b10, 1'b0, 6'h04, 32'h0);

    // Random back-to-back traffic with req_valid held high (words 0..14).
    for (int n = 0; n < 40; n++) begin
      rsz = 2'($urandom_range(0, 3));
      send(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 59)), $urandom);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
    chk("drain", sb_q.size(), 0);

    // Reset while a word store is in WRITE: RAM mode returns to read at once.
    send(1'b1, 2'b10, 1'b0, 6'h3C, 32'h0BADF00D);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_ram_rw", {31'h0, ram_rw}, 32'h0);
    rst = 1'b1;
    sb_q.delete();
    last_rdata = 32'h0;
    last_err   = 1'b0;
    #1;
    chk("mid_rst_ram_rw", {31'h0, ram_rw}, 32'h1);
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    chk("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);

    // Normal operation after reset.
    send(1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    send(1'b0, 2'b00, 1'b0, 6'h0A, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
    chk("final_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store front end for the MIPS data memory: accepts byte, halfword and word requests from the MEM pipeline stage and drives the word-wide, read-when-rw=1 / write-when-rw=0 data RAM directly upstream of it. Performs big-endian lane extraction with sign/zero extension on loads and read-modify-write on sub-word stores. One request in flight at a time; completion signalled by a one-cycle response pulse.

## Interface
- AW, 4: RAM word-address width; byte address is AW+2 bits
- DW, 32: data width, fixed at 32 (other values unsupported)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle, request accepted on clk edge when both high
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  AW+2  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_rdata  out  32  load result (0 for stores), valid with resp_valid
- resp_err  out  1  misaligned access flag, valid with resp_valid
- ram_addr  out  AW  RAM word address (registered)
- ram_rw  out  1  RAM mode, 1 read / 0 write (registered)
- ram_wdata  out  32  RAM write data (registered)
- ram_rdata  in  32  RAM read data, combinational from ram_addr

## Operation
- States: IDLE, READ, SETUP, WRITE, DONE. req_ready = (state == IDLE).
- Accept in IDLE: latch addr, size, signed, we, wdata; ram_addr <= req_addr[AW+1:2].
- Load: IDLE -> READ (capture ram_rdata, extract lane) -> DONE.
- Word store: IDLE -> SETUP (ram_wdata <= req_wdata, ram_rw stays 1) -> WRITE (ram_rw = 0) -> DONE.
- Sub-word store: IDLE -> READ (capture old word) -> SETUP (ram_wdata <= merged word) -> WRITE -> DONE.
- DONE: resp_valid = 1 for one cycle, ram_rw = 1, then IDLE.
- Big-endian lanes: byte offset 0 = bits 31:24, 3 = bits 7:0; half offset 0 = bits 31:16, 2 = bits 15:0.
- Loads: selected lane extended to 32 bits per req_signed; word load ignores req_signed.
- ram_rw is 0 only in WRITE, exactly one cycle; ram_addr and ram_wdata are stable from the preceding cycle through WRITE and change only in IDLE/SETUP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, ram_rw 1, ram_addr 0, ram_wdata 0.
- Reset mid-operation: immediate return to IDLE, ram_rw forced to 1 asynchronously, no response issued; a word in WRITE when reset asserts has undefined content.
- req_valid while not in IDLE is ignored (not latched).

## Timing
- Accept edge = cycle 0. resp_valid high in cycle: load 2, word store 3, sub-word store 4, misaligned error 1.
- Throughput: one request per 3 (load), 4 (word store), 5 (sub-word store) cycles including IDLE.
- resp_rdata and resp_err hold their values until the next response.

## Configuration
- MEM_ACCESS_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> DONE, resp_err = 1, resp_rdata = 0, RAM untouched (ram_rw never 0).
- Undefined: resp_err tied 0; half ignores addr[0], word ignores addr[1:0]; access proceeds normally.

## Structure
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, lane-offset constants.
- Sub-module mem_lane_align: purely combinational extract (word, offset, size, signed -> 32-bit result) and merge (old word, new data, offset, size -> merged word); FSM and registers stay in mem_access_ctrl.

## Test plan
- Reset: rst high mid-run -> ram_rw = 1, req_ready = 1, resp_valid = 0 same cycle, no response afterwards.
- SW 0xDEADBEEF to 0x08 -> ram_addr = 2, ram_rw = 0 in cycle 2 only, resp_valid cycle 3; LW 0x08 -> 0xDEADBEEF in cycle 2.
- Word 0x11223344 at 0x08; SB 0x000000AA to 0x09 -> RAM word 0x11AA3344, resp_valid cycle 4; SH 0x0000BEEF to 0x0A -> 0x11AABEEF.
- Word 0x112233F0 at 0x08: LB signed 0x0B -> 0xFFFFFFF0; LBU 0x0B -> 0x000000F0; LH signed 0x0A -> 0x000033F0; LH signed 0x08 -> 0x00001122.
- LW 0x06 with macro -> resp_err = 1 in cycle 1, ram_rw never 0; without macro -> returns word at 0x04, resp_err = 0.
- req_valid held high through a store -> second request accepted only after DONE, back-to-back responses never overlap.
